mio_bus: RTL
============

# mio_bus

Memory/IO bus controller sitting directly downstream of the multi-cycle CPU's memory port. It accepts the CPU's bus request (CPU_MIO, mem_w, address, write data), decodes the address into RAM, GPIO or counter space, and inserts wait states. It returns read data plus a one-cycle MIO_ready completion pulse, which is what stalls and advances the CPU controller. It also owns the GPIO output register and a loadable free-running 32-bit counter.

## Interface
- RAM_WAIT, 1: wait cycles for RAM accesses; legal range 1..15.
- IO_WAIT, 0: wait cycles for GPIO/counter accesses; legal range 0..15.
- RAM_AW, 10: RAM word-address width.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_mio  in  1  CPU bus request (level).
- mem_w  in  1  1 = write, 0 = read.
- addr_bus  in  32  byte address.
- cpu_wdata  in  32  write data from the CPU.
- cpu_rdata  out  32  read data to the CPU's Data_in.
- mio_ready  out  1  transaction-complete pulse.
- ram_addr  out  RAM_AW  RAM word address, equal to addr_bus[RAM_AW+1:2] (combinational).
- ram_din  out  32  equal to cpu_wdata.
- ram_we  out  1  RAM write strobe.
- ram_dout  in  32  synchronous RAM read data, valid one cycle after the address.
- sw_in  in  16  switch inputs.
- gpio_out  out  32  GPIO/LED register.
- bus_err  out  1  sticky flag for an unmapped access.

## Operation
- Address decode uses addr_bus[31:28]:
  - 0x0 is RAM. Bits above RAM_AW+2 are ignored, so RAM aliases.
  - 0xE is GPIO. A write loads gpio_out. A read returns {16'h0, sw_in}.
  - 0xF is the counter. A read returns the counter. A write loads the counter.
  - Any other value is unmapped: reads return 0, writes are dropped, and bus_err is set. The access still completes normally.
- addr_bus[1:0] are ignored; all accesses are word accesses.
- The CPU holds addr_bus, mem_w and cpu_wdata stable from request until it samples mio_ready=1.
- FSM states:
  - IDLE: if cpu_mio=1, latch the region and mem_w, load the wait counter with RAM_WAIT (RAM) or IO_WAIT (GPIO/counter/unmapped). Go to WAIT if the loaded value is nonzero, otherwise go to READY.
  - WAIT: decrement the counter and go to READY when it reaches 1. If cpu_mio drops, abort back to IDLE with no write and no ready.
  - READY: mio_ready=1. For writes, ram_we=1 in this cycle when the region is RAM; GPIO/counter registers update at the edge ending this cycle. Always return to IDLE.
- Read data is captured into the cpu_rdata register at the edge entering READY:
  - RAM reads capture ram_dout.
  - IO reads capture the sw_in or counter value at that edge.
  - cpu_rdata holds its value until the next read capture; writes do not change it.
- Counter: increments by 1 every cycle and wraps 0xFFFFFFFF -> 0. A write loads cpu_wdata and takes priority over the increment in that cycle.
- Back-to-back transactions: the IDLE cycle after READY samples cpu_mio again, so a still-asserted request starts a new transaction. There is exactly one idle cycle between transactions.
- bus_err is set at the edge ending READY of an unmapped access. Only reset clears it.

## Timing
- On reset assertion (asynchronous): FSM goes to IDLE; mio_ready=0, ram_we=0, cpu_rdata=0, gpio_out=0, counter=0, bus_err=0.
- Reset mid-transaction aborts it with no write. The first request after reset deassertion is sampled at the next rising edge.
- Latency from the request sampled in IDLE (edge t) to mio_ready high: WAIT+1 cycles.
  - RAM with RAM_WAIT=1: mio_ready is high during cycle t+2.
  - IO with IO_WAIT=0: mio_ready is high during cycle t+1.
- With RAM_WAIT=1, ram_addr presented in the IDLE cycle gives ram_dout valid in the WAIT cycle, captured at the edge entering READY.
- mio_ready and ram_we are exactly one cycle wide, both registered (decoded from the state register).
- ram_we never asserts for reads, aborted transactions, or non-RAM regions.

## Test plan
- RAM read, RAM_WAIT=1: preload word 5 with 0xDEADBEEF, request addr 0x14 read -> mio_ready high 2 cycles after acceptance, cpu_rdata=0xDEADBEEF, ram_we stays 0.
- RAM write then read back-to-back: write 0x12345678 to 0x20 with cpu_mio held -> ram_we one cycle with ram_addr=8, one IDLE gap, then the read returns 0x12345678.
- GPIO: write 0x000000A5 to 0xE0000000 -> gpio_out=0xA5 after READY. With sw_in=0x1234, reading 0xE0000004 -> cpu_rdata=0x00001234, mio_ready 1 cycle after acceptance (IO_WAIT=0).
- Counter: write 0xFFFFFFFE to 0xF0000000, then read on the following transaction -> value equals 0xFFFFFFFE plus the elapsed cycles, modulo 2^32 (wrap observed). A load in the same cycle as an increment yields the loaded value.
- Unmapped/abort: read 0x50000000 -> cpu_rdata=0, bus_err=1 and stays set. With RAM_WAIT=3, dropping cpu_mio in the 2nd WAIT cycle -> no mio_ready, no ram_we, FSM back in IDLE.
- Reset mid-WAIT of a RAM write: assert reset asynchronously -> all outputs return to reset values immediately, and the RAM content is unchanged.

Source files
------------

// File: rtl/mio_bus.sv
// Memory/IO bus controller: decodes CPU requests into RAM, GPIO or counter space,
// inserts wait states and returns read data with a one-cycle mio_ready pulse.
module mio_bus #(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 0,
  parameter int unsigned RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [31:0]       gpio_out,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;
  typedef enum logic [1:0] {R_RAM, R_GPIO, R_CNT, R_NONE} region_e;

  localparam logic [3:0] RAM_W4 = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W4  = 4'(IO_WAIT);

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  logic        wr_q, wr_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  region_e     dec_region;
  region_e     cap_region;
  logic        cap;
  logic        unused_addr;

  assign unused_addr = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

  always_comb begin
    unique case (addr_bus[31:28])
      4'h0:    dec_region = R_RAM;
      4'hE:    dec_region = R_GPIO;
      4'hF:    dec_region = R_CNT;
      default: dec_region = R_NONE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    wr_d       = wr_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    gpio_d     = gpio_q;
    cnt_d      = cnt_q + 32'd1;
    err_d      = err_q;
    cap        = 1'b0;
    cap_region = region_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_mio) begin
          region_d = dec_region;
          wr_d     = mem_w;
          wcnt_d   = (dec_region == R_RAM) ? RAM_W4 : IO_W4;
          if (wcnt_d != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            // Zero-wait access: capture uses the live decode, not the latched region.
            state_d    = S_READY;
            cap        = !mem_w;
            cap_region = dec_region;
          end
        end
      end
      S_WAIT: begin
        if (!cpu_mio) begin
          state_d = S_IDLE;
        end else if (wcnt_q <= 4'd1) begin
          state_d = S_READY;
          cap     = !wr_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        if (wr_q && region_q == R_GPIO) gpio_d = cpu_wdata;
        if (wr_q && region_q == R_CNT)  cnt_d  = cpu_wdata;
        if (region_q == R_NONE)         err_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap) begin
      unique case (cap_region)
        R_RAM:   rdata_d = ram_dout;
        R_GPIO:  rdata_d = {16'h0, sw_in};
        R_CNT:   rdata_d = cnt_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      region_q <= R_RAM;
      wr_q     <= 1'b0;
      wcnt_q   <= '0;
      rdata_q  <= '0;
      gpio_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wr_q     <= wr_d;
      wcnt_q   <= wcnt_d;
      rdata_q  <= rdata_d;
      gpio_q   <= gpio_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign mio_ready = (state_q == S_READY);
  assign ram_we    = (state_q == S_READY) && wr_q && (region_q == R_RAM);
  assign ram_addr  = addr_bus[RAM_AW+1:2];
  assign ram_din   = cpu_wdata;
  assign cpu_rdata = rdata_q;
  assign gpio_out  = gpio_q;
  assign bus_err   = err_q;

endmodule
